// File: rtl/link_pkg.sv
// link_pkg: shared constants, CRC-32 step and 8b/10b encode/decode tables for the packet link
package link_pkg;
  localparam int SYNC_CNT = 4;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [8:0] K28_1 = 9'h13C;
  localparam logic [8:0] K28_5 = 9'h1BC;
  localparam logic [8:0] K23_7 = 9'h1F7;
  localparam logic [5:0] D6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] D4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [8:0] KSYM [12] = '{
    9'h11C, 9'h13C, 9'h15C, 9'h17C, 9'h19C, 9'h1BC, 9'h1DC, 9'h1FC,
    9'h1F7, 9'h1FB, 9'h1FD, 9'h1FE};
  typedef enum logic [2:0] {HUNT, SYNC, DATA, TRL, END} rx_state_e;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
    return c;
  endfunction
  function automatic logic [5:0] enc6(input logic [4:0] x, input logic rdp);
    logic [5:0] n;
    n = D6[x];
    return (rdp && ($countones(n) != 3 || x == 5'd7)) ? ~n : n;
  endfunction
  function automatic logic [9:0] enc10(input logic [8:0] sym, input logic rdp);
    logic [4:0] x;
    logic [2:0] y;
    logic k28, a7, rd1;
    logic [5:0] s6;
    logic [3:0] s4;
    x = sym[4:0];
    y = sym[7:5];
    k28 = sym[8] && x == 5'd28;
    s6 = k28 ? (rdp ? 6'b110000 : 6'b001111) : enc6(x, rdp);
    rd1 = rdp ^ ($countones(s6) != 3);
    a7 = sym[8] || (rd1 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                        : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    s4 = (y == 3'd7 && a7) ? 4'b0111 : D4[y];
    s4 = (k28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6)) ? ~s4 : s4;
    s4 = (rd1 && ($countones(s4) != 2 || y == 3'd3 || k28)) ? ~s4 : s4;
    return {s6, s4};
  endfunction
  function automatic logic [9:0] dec10(input logic [9:0] code, input logic rdp);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      if (enc10({1'b0, 8'(i)}, rdp) == code) r = {1'b1, 1'b0, 8'(i)};
    for (int i = 0; i < 12; i++)
      if (enc10(KSYM[i], rdp) == code) r = {1'b1, KSYM[i]};
    return r;
  endfunction
endpackage

// File: rtl/link_rx_if.sv
// link_rx_if: receiver symbol input and payload/status output bundle (master drives pushin/datain)
interface link_rx_if;
  logic pushin;
  logic [9:0] datain;
  logic pushout;
  logic [8:0] dataout;
  logic startout;
  logic doneout;
  logic crc_ok;
  logic code_err;
  logic frame_err;
  modport master (output pushin, datain,
                  input pushout, dataout, startout, doneout, crc_ok, code_err, frame_err);
  modport slave (input pushin, datain,
                 output pushout, dataout, startout, doneout, crc_ok, code_err, frame_err);
endinterface

// File: rtl/link_rx_tbeb.sv
// tbeb: 10b->9b decoder with running-disparity register (clk, reset, push, code -> sym, err)
module tbeb
  import link_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [9:0] code,
  output logic [8:0] sym,
  output logic       err
);
  logic rd;
  logic [9:0] cur, alt;
  always_comb begin
    cur = dec10(code, rd);
    alt = dec10(code, ~rd);
    sym = cur[9] ? cur[8:0] : alt[8:0];
    err = !cur[9];
  end
  always_ff @(posedge clk)
    if (reset) rd <= 1'b0;
    else if (push) rd <= $countones(code) > 5 ? 1'b1 : ($countones(code) < 5 ? 1'b0 : rd);
endmodule

// File: rtl/link_rx.sv
// link_rx: 8b/10b + CRC-32 packet receiver (clk, reset, link_rx_if.slave lnk: symbols in, payload/status out)
module link_rx
  import link_pkg::*;
(
  input logic clk,
  input logic reset,
  link_rx_if.slave lnk
);
  rx_state_e st;
  logic [8:0] sym;
  logic err, ks1, ks5, k237, cerr_n;
  logic [2:0] cnt;
  logic [1:0] tcnt;
  logic [31:0] crc_q, rx_crc;
  logic cerr_q;
  tbeb u_dec (.clk(clk), .reset(reset), .push(lnk.pushin), .code(lnk.datain), .sym(sym), .err(err));
  always_comb begin
    ks1 = sym == K28_1;
    ks5 = sym == K28_5;
    k237 = sym == K23_7;
    cerr_n = cerr_q | err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= HUNT;
      cnt <= '0;
      tcnt <= '0;
      crc_q <= CRC_INIT;
      rx_crc <= '0;
      cerr_q <= 1'b0;
      lnk.pushout <= 1'b0;
      lnk.dataout <= '0;
      lnk.startout <= 1'b0;
      lnk.doneout <= 1'b0;
      lnk.crc_ok <= 1'b0;
      lnk.code_err <= 1'b0;
      lnk.frame_err <= 1'b0;
    end else begin
      lnk.pushout <= 1'b0;
      lnk.startout <= 1'b0;
      lnk.doneout <= 1'b0;
      lnk.crc_ok <= 1'b0;
      lnk.code_err <= 1'b0;
      lnk.frame_err <= 1'b0;
      if (lnk.pushin) begin
        case (st)
          HUNT: begin
            cnt <= ks1 ? cnt + 3'd1 : 3'd0;
            if (ks1 && cnt == 3'(SYNC_CNT - 1)) begin
              st <= SYNC;
              cnt <= 3'd0;
              cerr_q <= 1'b0;
            end
          end
          SYNC: begin
            if (ks5 || k237) begin
              st <= HUNT;
              lnk.doneout <= 1'b1;
              lnk.frame_err <= 1'b1;
              lnk.code_err <= cerr_n;
            end else if (!ks1) begin
              st <= DATA;
              lnk.pushout <= 1'b1;
              lnk.startout <= 1'b1;
              lnk.dataout <= sym;
              crc_q <= crc32_byte(CRC_INIT, sym[7:0]);
              cerr_q <= cerr_n;
            end
          end
          DATA: begin
            if (k237) begin
              st <= TRL;
              tcnt <= 2'd0;
              cerr_q <= cerr_n;
            end else if (ks5 || ks1) begin
              st <= HUNT;
              cnt <= {2'b00, ks1};
              lnk.doneout <= 1'b1;
              lnk.frame_err <= 1'b1;
              lnk.code_err <= cerr_n;
            end else begin
              lnk.pushout <= 1'b1;
              lnk.dataout <= sym;
              crc_q <= crc32_byte(crc_q, sym[7:0]);
              cerr_q <= cerr_n;
            end
          end
          TRL: begin
            if (sym[8]) begin
              st <= HUNT;
              lnk.doneout <= 1'b1;
              lnk.frame_err <= 1'b1;
              lnk.code_err <= cerr_n;
            end else begin
              rx_crc <= {sym[7:0], rx_crc[31:8]};
              tcnt <= tcnt + 2'd1;
              cerr_q <= cerr_n;
              st <= tcnt == 2'd3 ? END : TRL;
            end
          end
          END: begin
            st <= HUNT;
            lnk.doneout <= 1'b1;
            lnk.code_err <= cerr_n;
            lnk.frame_err <= !ks5;
            lnk.crc_ok <= ks5 && rx_crc == ~crc_q;
          end
          default: st <= HUNT;
        endcase
      end
    end
  end
endmodule
